// File: rtl/sia_work_dispatch.sv
// Work dispatcher in front of siacore: queues host work items, issues them one at a
// time, and returns found nonces or watchdog timeouts tagged with the work ID.
module sia_work_dispatch #(
    parameter int          DEPTH       = 2,
    parameter int          ID_W        = 8,
    parameter logic [31:0] TIMEOUT_CYC = 32'hFFFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [639:0]    in_work,
    input  logic [63:0]     in_target,
    input  logic [ID_W-1:0] in_id,
    output logic [639:0]    core_work,
    output logic [63:0]     core_target,
    output logic            core_valid,
    input  logic            core_busy,
    input  logic            core_found,
    input  logic [31:0]     core_nonce,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ID_W-1:0] res_id,
    output logic [31:0]     res_nonce,
    output logic            res_timeout,
    output logic [31:0]     stat_hashes
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    logic [639:0]    work_mem_q   [DEPTH];
    logic [63:0]     target_mem_q [DEPTH];
    logic [ID_W-1:0] id_mem_q     [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     wd_q, wd_d;
    logic [639:0]    core_work_q, core_work_d;
    logic [63:0]     core_target_q, core_target_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [31:0]     res_nonce_q, res_nonce_d;
    logic            res_timeout_q, res_timeout_d;
    logic [31:0]     stat_q, stat_d;
    logic            push_s, pop_s, expired_s;

    // No bypass: a full FIFO refuses input even while the head is being popped.
    assign in_ready  = (count_q != CNT_FULL);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = (state_q == S_REPORT) & res_ready;
    assign expired_s = (wd_q == (TIMEOUT_CYC - 32'd1));

    // Work item storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            work_mem_q[wr_ptr_q]   <= in_work;
            target_mem_q[wr_ptr_q] <= in_target;
            id_mem_q[wr_ptr_q]     <= in_id;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            wd_q          <= 32'd0;
            core_work_q   <= 640'd0;
            core_target_q <= 64'd0;
            res_id_q      <= {ID_W{1'b0}};
            res_nonce_q   <= 32'd0;
            res_timeout_q <= 1'b0;
            stat_q        <= 32'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wd_q          <= wd_d;
            core_work_q   <= core_work_d;
            core_target_q <= core_target_d;
            res_id_q      <= res_id_d;
            res_nonce_q   <= res_nonce_d;
            res_timeout_q <= res_timeout_d;
            stat_q        <= stat_d;
        end
    end

    // Next-state logic; a found pulse in ISSUE means the core finished before busy was seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != {CW{1'b0}}) && !core_busy) state_d = S_ISSUE;
                else                                       state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (core_found)     state_d = S_REPORT;
                else if (core_busy) state_d = S_RUN;
                else                state_d = S_ISSUE;
            end
            S_RUN: begin
                if (core_found || expired_s) state_d = S_REPORT;
                else                         state_d = S_RUN;
            end
            S_REPORT: begin
                if (res_ready) state_d = S_IDLE;
                else           state_d = S_REPORT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers, watchdog, issued item and result capture
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        wd_d          = wd_q;
        core_work_d   = core_work_q;
        core_target_d = core_target_q;
        res_id_d      = res_id_q;
        res_nonce_d   = res_nonce_q;
        res_timeout_d = res_timeout_q;
        stat_d        = stat_q;

        if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        else        rd_ptr_d = rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (state_q == S_RUN) wd_d = wd_q + 32'd1;
        else if (pop_s)       wd_d = 32'd0;
        else                  wd_d = wd_q;

        if ((state_q == S_IDLE) && (state_d == S_ISSUE)) begin
            core_work_d   = work_mem_q[rd_ptr_q];
            core_target_d = target_mem_q[rd_ptr_q];
            res_id_d      = id_mem_q[rd_ptr_q];
        end else begin
            core_work_d   = core_work_q;
            core_target_d = core_target_q;
            res_id_d      = res_id_q;
        end

        if (((state_q == S_ISSUE) || (state_q == S_RUN)) && core_found) begin
            res_nonce_d   = core_nonce;
            res_timeout_d = 1'b0;
        end else if ((state_q == S_RUN) && expired_s) begin
            res_nonce_d   = 32'd0;
            res_timeout_d = 1'b1;
        end else begin
            res_nonce_d   = res_nonce_q;
            res_timeout_d = res_timeout_q;
        end

        if (core_busy && (stat_q != 32'hFFFFFFFF)) stat_d = stat_q + 32'd1;
        else                                       stat_d = stat_q;
    end

    // Outputs decoded from registered state
    always_comb begin
        core_valid  = (state_q == S_ISSUE);
        res_valid   = (state_q == S_REPORT);
        core_work   = core_work_q;
        core_target = core_target_q;
        res_id      = res_id_q;
        res_nonce   = res_nonce_q;
        res_timeout = res_timeout_q;
        stat_hashes = stat_q;
    end
endmodule

// File: tb/tb_sia_work_dispatch.sv
// Randomized self-checking bench for sia_work_dispatch; the bench itself plays host and
// siacore and predicts results from a queue of accepted work items.
module tb_sia_work_dispatch;
    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0]   id;
        logic [639:0] work;
        logic [63:0]  target;
    } item_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [639:0] in_work = 640'd0;
    logic [63:0]  in_target = 64'd0;
    logic [7:0]   in_id = 8'd0;
    logic [639:0] core_work;
    logic [63:0]  core_target;
    logic         core_valid;
    logic         core_busy = 1'b0, core_found = 1'b0;
    logic [31:0]  core_nonce = 32'd0;
    logic         res_valid, res_ready = 1'b0;
    logic [7:0]   res_id;
    logic [31:0]  res_nonce;
    logic         res_timeout;
    logic [31:0]  stat_hashes;

    int    checks = 0;
    int    passes = 0;
    item_t hq[$];
    item_t mq[$];
    logic [31:0] model_hashes = 32'd0;

    sia_work_dispatch #(.DEPTH(DEPTH), .ID_W(8), .TIMEOUT_CYC(32'd16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_work(in_work),
        .in_target(in_target), .in_id(in_id),
        .core_work(core_work), .core_target(core_target), .core_valid(core_valid),
        .core_busy(core_busy), .core_found(core_found), .core_nonce(core_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_nonce(res_nonce), .res_timeout(res_timeout), .stat_hashes(stat_hashes)
    );

    always #5 clk = ~clk;

    function automatic item_t rand_item(input logic [7:0] id);
        item_t it;
        it.id = id;
        for (int i = 0; i < 20; i++) it.work[i*32 +: 32] = $urandom;
        it.target = {$urandom, $urandom};
        return it;
    endfunction

    task automatic drive_host();
        if (hq.size() > 0) begin
            in_valid = 1'b1; in_id = hq[0].id; in_work = hq[0].work; in_target = hq[0].target;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: the host model pushes when the modelled FIFO has room.
    task automatic tick();
        bit acc;
        acc = in_valid && (mq.size() < DEPTH) && !rst;
        @(posedge clk);
        if (rst) begin
            mq.delete(); hq.delete(); model_hashes = 32'd0;
        end else begin
            if (core_busy && model_hashes != 32'hFFFFFFFF) model_hashes = model_hashes + 32'd1;
            if (acc) mq.push_back(hq.pop_front());
        end
        #1;
        drive_host();
    endtask

    task automatic wait_issue(input string name);
        int waited = 0;
        while (core_valid !== 1'b1 && waited < 40) begin tick(); waited++; end
        checks++;
        if (core_valid !== 1'b1 || mq.size() == 0)
            $display("FAIL %s_issue core_valid=%b queued=%0d expected core_valid=1", name, core_valid, mq.size());
        else passes++;
    endtask

    // Issue the head item, let the core hash busy_len cycles, find nonce, hold res_ready low.
    task automatic serve_one(input string name, input int busy_len, input logic [31:0] nonce, input int hold);
        item_t exp;
        wait_issue(name);
        if (mq.size() == 0) return;
        exp = mq[0];
        checks++; if (core_work !== exp.work) $display("FAIL %s_work got %h exp %h", name, core_work, exp.work); else passes++;
        checks++; if (core_target !== exp.target) $display("FAIL %s_target got %h exp %h", name, core_target, exp.target); else passes++;
        core_busy = 1'b1;
        repeat (busy_len) tick();
        core_busy = 1'b0; core_found = 1'b1; core_nonce = nonce;
        tick();
        core_found = 1'b0; core_nonce = $urandom;
        checks++;
        if (res_valid !== 1'b1 || res_id !== exp.id || res_nonce !== nonce || res_timeout !== 1'b0)
            $display("FAIL %s_result got v=%b id=%h n=%h t=%b exp v=1 id=%h n=%h t=0", name, res_valid, res_id, res_nonce, res_timeout, exp.id, nonce);
        else passes++;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_id !== exp.id || res_nonce !== nonce || core_valid !== 1'b0)
                $display("FAIL %s_hold got v=%b id=%h n=%h cv=%b exp v=1 id=%h n=%h cv=0", name, res_valid, res_id, res_nonce, core_valid, exp.id, nonce);
            else passes++;
            checks++;
            if (in_ready !== (mq.size() < DEPTH)) $display("FAIL %s_hold_ready got %b exp %b", name, in_ready, mq.size() < DEPTH);
            else passes++;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        void'(mq.pop_front());
        checks++; if (res_valid !== 1'b0) $display("FAIL %s_release res_valid got %b exp 0", name, res_valid); else passes++;
    endtask

    task automatic check_stats(input string name);
        checks++;
        if (stat_hashes !== model_hashes) $display("FAIL %s_stat got %0d exp %0d", name, stat_hashes, model_hashes);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || core_valid !== 1'b0 || res_valid !== 1'b0 || stat_hashes !== 32'd0)
            $display("FAIL reset_ctrl got rdy=%b cv=%b rv=%b st=%0d exp 1 0 0 0", in_ready, core_valid, res_valid, stat_hashes);
        else passes++;
        checks++;
        if (res_id !== 8'd0 || res_nonce !== 32'd0 || res_timeout !== 1'b0 || core_work !== 640'd0 || core_target !== 64'd0)
            $display("FAIL reset_data got id=%h n=%h t=%b exp all zero", res_id, res_nonce, res_timeout);
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if (core_valid !== 1'b0 || res_valid !== 1'b0) $display("FAIL reset_idle got cv=%b rv=%b exp 0 0", core_valid, res_valid);
        else passes++;
    endtask

    task automatic test_single();
        hq.push_back(rand_item(8'h05));
        drive_host();
        tick();
        checks++; if (core_valid !== 1'b0) $display("FAIL single_lat1 core_valid got %b exp 0", core_valid); else passes++;
        tick();
        checks++; if (core_valid !== 1'b1) $display("FAIL single_lat2 core_valid got %b exp 1", core_valid); else passes++;
        serve_one("single", 4, 32'h1234ABCD, 0);
        checks++; if (stat_hashes !== 32'd4) $display("FAIL single_stat got %0d exp 4", stat_hashes); else passes++;
    endtask

    task automatic test_back_to_back();
        hq.push_back(rand_item(8'h11));
        hq.push_back(rand_item(8'h12));
        hq.push_back(rand_item(8'h13));
        drive_host();
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b exp 1", in_ready); else passes++;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_full got %b exp 0", in_ready); else passes++;
        serve_one("b2b_a", 2, $urandom, 0);
        checks++; if (in_ready !== 1'b1 || hq.size() != 1) $display("FAIL b2b_nobypass got rdy=%b pending=%0d exp 1 1", in_ready, hq.size()); else passes++;
        serve_one("b2b_b", 1, $urandom, 0);
        serve_one("b2b_c", 3, $urandom, 0);
        check_stats("b2b");
    endtask

    task automatic test_timeout();
        item_t t1;
        hq.push_back(rand_item(8'h31));
        drive_host();
        wait_issue("tmo");
        t1 = mq[0];
        core_busy = 1'b1;
        tick();
        hq.push_back(rand_item(8'h32));
        drive_host();
        repeat (15) tick();
        checks++; if (res_valid !== 1'b0) $display("FAIL tmo_early res_valid got %b exp 0", res_valid); else passes++;
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_nonce !== 32'd0 || res_id !== t1.id)
            $display("FAIL tmo_result got v=%b t=%b n=%h id=%h exp 1 1 0 %h", res_valid, res_timeout, res_nonce, res_id, t1.id);
        else passes++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        void'(mq.pop_front());
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (core_valid !== 1'b0) $display("FAIL tmo_wait_busy core_valid got %b exp 0", core_valid); else passes++;
        end
        core_busy = 1'b0;
        tick();
        checks++; if (core_valid !== 1'b1) $display("FAIL tmo_reissue core_valid got %b exp 1", core_valid); else passes++;
        serve_one("tmo_next", 3, $urandom, 0);
        check_stats("tmo");
    endtask

    task automatic test_found_at_expiry();
        logic [31:0] n;
        n = $urandom;
        hq.push_back(rand_item(8'h41));
        drive_host();
        wait_issue("race");
        core_busy = 1'b1;
        tick();
        repeat (15) tick();
        checks++; if (res_valid !== 1'b0) $display("FAIL race_early res_valid got %b exp 0", res_valid); else passes++;
        core_found = 1'b1; core_nonce = n;
        tick();
        core_found = 1'b0; core_busy = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_nonce !== n || res_id !== 8'h41)
            $display("FAIL race_result got v=%b t=%b n=%h id=%h exp 1 0 %h 41", res_valid, res_timeout, res_nonce, res_id, n);
        else passes++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        void'(mq.pop_front());
        check_stats("race");
    endtask

    task automatic test_stall();
        hq.push_back(rand_item(8'h51));
        hq.push_back(rand_item(8'h52));
        hq.push_back(rand_item(8'h53));
        drive_host();
        serve_one("stall", 2, $urandom, 10);
        serve_one("stall_b", 0, $urandom, 2);
        serve_one("stall_c", 1, $urandom, 0);
        check_stats("stall");
    endtask

    task automatic test_random();
        int n = 0;
        for (int i = 0; i < 6; i++) hq.push_back(rand_item(8'($urandom)));
        drive_host();
        while ((mq.size() > 0 || hq.size() > 0) && n < 12) begin
            serve_one("rand", $urandom_range(0, 10), $urandom, $urandom_range(0, 3));
            n++;
        end
        checks++; if (mq.size() != 0 || hq.size() != 0) $display("FAIL rand_drain left=%0d exp 0", mq.size() + hq.size()); else passes++;
        check_stats("rand");
    endtask

    task automatic test_reset_mid_run();
        hq.push_back(rand_item(8'h61));
        hq.push_back(rand_item(8'h62));
        drive_host();
        wait_issue("mrst");
        core_busy = 1'b1;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL mrst_full in_ready got %b exp 0", in_ready); else passes++;
        rst = 1'b1;
        tick();
        checks++;
        if (core_valid !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || stat_hashes !== 32'd0)
            $display("FAIL mrst_state got cv=%b rv=%b rdy=%b st=%0d exp 0 0 1 0", core_valid, res_valid, in_ready, stat_hashes);
        else passes++;
        rst = 1'b0; core_busy = 1'b0;
        tick();
        hq.push_back(rand_item(8'h63));
        drive_host();
        serve_one("mrst_after", 2, $urandom, 0);
        check_stats("mrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_found_at_expiry();
        test_stall();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
